ps2_event_sequencer: RTL and testbench
======================================

# ps2_event_sequencer

Sequences the raw PS/2 byte stream from the keyboard receiver into clean key events for the LED controller and later consumers. It strips E0 (extended) and F0 (break) prefixes and tracks held state for the A/B/C/D keys. It suppresses typematic repeats, buffers events in a small FIFO, and presents them over a valid/ready handshake. It sits between the keyboard receiver and any event consumer, so downstream logic no longer sees break codes as presses.

## Interface
- FIFO_DEPTH, 4, event queue depth; power of two, 2..16
- REPEAT_FILTER, 1, 1 = drop repeated presses of a tracked key that is already held; 0 = forward every press
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the clk edge where reset=1
- byte_in  in  8  received PS/2 byte
- byte_valid  in  1  one-cycle strobe; byte_in is valid this cycle
- evt_code  out  8  head event scan code (final byte, prefixes removed)
- evt_ext  out  1  head event was E0-prefixed
- evt_release  out  1  head event was F0-prefixed (key released)
- evt_valid  out  1  FIFO non-empty; head event presented
- evt_ready  in  1  consumer accepts head when evt_valid=1
- key_down  out  4  held state: [0]=A 0x1C, [1]=B 0x32, [2]=C 0x21, [3]=D 0x23; non-extended codes only
- overflow  out  1  sticky; set when a completed event is dropped because the FIFO is full

## Operation
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on cycles with byte_valid=1.
- IDLE handling:
  - E0 -> EXT.
  - F0 -> BRK.
  - 0x00, 0xAA, 0xFA, 0xFE, 0xFF are discarded and the FSM stays in IDLE.
  - Any other byte completes an event {ext=0, rel=0}.
- EXT handling:
  - F0 -> EXT_BRK.
  - E0 stays in EXT.
  - Any other byte completes {ext=1, rel=0} and returns to IDLE.
- BRK handling:
  - E0 -> EXT_BRK, so E0 and F0 are accepted in either order.
  - F0 stays in BRK.
  - Any other byte completes {ext=0, rel=1} and returns to IDLE.
- EXT_BRK handling:
  - E0 or F0 stays in EXT_BRK.
  - Any other byte completes {ext=1, rel=1} and returns to IDLE.
- Tracked keys are the four listed codes with ext=0. Completed events are handled as follows:
  - Tracked release: clear the key_down bit and enqueue the event.
  - Tracked press with its bit already 1 and REPEAT_FILTER=1: do not enqueue. key_down is unchanged.
  - Tracked press otherwise: set the bit and enqueue the event.
  - Untracked code, or any ext=1 code: always enqueue. key_down is unaffected.
- FIFO entry is {ext, rel, code}, 10 bits, with show-ahead head outputs.
  - Pop occurs when evt_valid and evt_ready are both 1.
- Push is accepted if the FIFO is not full, or if it is full and a pop occurs the same cycle.
  - Otherwise the event is dropped and overflow is set.
  - key_down still updates for a dropped event.
- overflow is cleared only by reset.
- Occupancy counter width is log2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: evt_valid=0, evt_code=0, evt_ext=0, evt_release=0, key_down=0, overflow=0, FSM=IDLE, FIFO empty.
- Latency: the byte completing an event at edge N gives evt_valid=1 with the new head after edge N when the FIFO was empty. key_down updates on the same edge N.
- Pop: the head advances on the edge where evt_valid and evt_ready are both 1. evt_valid falls after that edge if it was the last entry.
- Empty FIFO with push and evt_ready=1 the same cycle: no bypass. The event appears one cycle later.
- Full FIFO with push and pop the same cycle: both happen, occupancy stays FIFO_DEPTH, and overflow stays unchanged.
- evt_ready while evt_valid=0 is ignored.
- Head outputs hold stable while evt_valid=1 and evt_ready=0.
- Reset mid-prefix (e.g. after F0) discards the partial sequence and all queued events. The next 0x1C is then a press.
- byte_valid on back-to-back cycles is supported at full rate.

## Test plan
- Press A, then release A:
  - Bytes 1C gives event {0,0,0x1C}, then key_down=0001.
  - Bytes F0,1C gives event {0,1,0x1C}, then key_down=0000.
- Typematic, REPEAT_FILTER=1: bytes 1C,1C,1C then F0,1C gives exactly two events (press, release), and overflow=0.
- Extended key, either prefix order: bytes E0,F0,75 and F0,E0,75 each give {ext=1,rel=1,0x75}. key_down stays 0000.
- Backpressure with evt_ready=0:
  - Send five untracked presses 0x15, 0x1D, 0x24, 0x2D, 0x2C, giving 4 events queued and overflow=1.
  - Then set evt_ready=1; the drain order is 0x15, 0x1D, 0x24, 0x2D and evt_valid falls.
- Full FIFO with simultaneous push and pop: with the FIFO full, assert evt_ready=1 while a completing byte arrives. Occupancy stays 4, overflow stays 0, and the new event is the last drained.
- Reset mid-sequence: bytes F0, then reset, then 1C gives a press {0,0,0x1C} and key_down=0001.

Source files
------------

// File: rtl/ps2_event_sequencer.sv
// ps2_event_sequencer
//   Turns the raw PS/2 byte stream into clean key events. E0 (extended) and
//   F0 (break) prefixes are folded into flags on the final scan code. Held
//   state is tracked for the A/B/C/D keys, typematic repeats of held keys are
//   optionally suppressed, and events are queued in a small show-ahead FIFO
//   presented over a valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH    event queue depth, power of two, 2..16
//   REPEAT_FILTER 1 = drop presses of a tracked key that is already held
//
// Ports
//   clk          system clock
//   reset        synchronous active-high reset
//   byte_in      received PS/2 byte
//   byte_valid   one-cycle strobe qualifying byte_in
//   evt_code     head event scan code (prefixes removed)
//   evt_ext      head event was E0-prefixed
//   evt_release  head event was F0-prefixed
//   evt_valid    FIFO non-empty, head event presented
//   evt_ready    consumer accepts the head when evt_valid=1
//   key_down     held state: [0]=A 1C, [1]=B 32, [2]=C 21, [3]=D 23
//   overflow     sticky; an event was dropped because the FIFO was full
module ps2_event_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FILTER = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [3:0] key_down,
    output logic       overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t state, state_next;

    // Completed-event decode for the current byte
    logic       done;
    logic       done_ext;
    logic       done_rel;
    logic       ignored;

    // Tracked-key lookup
    logic       trk_hit;
    logic [1:0] trk_idx;

    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       full;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Link-level bytes that carry no key information when seen outside a prefix
    always_comb begin
        ignored = (byte_in == 8'h00) || (byte_in == 8'hAA) || (byte_in == 8'hFA) ||
                  (byte_in == 8'hFE) || (byte_in == 8'hFF);
    end

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        done_ext   = 1'b0;
        done_rel   = 1'b0;
        if (byte_valid) begin
            unique case (state)
                IDLE: begin
                    if (byte_in == BYTE_EXT)      state_next = EXT;
                    else if (byte_in == BYTE_BRK) state_next = BRK;
                    else if (!ignored)            done       = 1'b1;
                end
                EXT: begin
                    if (byte_in == BYTE_BRK)      state_next = EXT_BRK;
                    else if (byte_in != BYTE_EXT) begin
                        done       = 1'b1;
                        done_ext   = 1'b1;
                        state_next = IDLE;
                    end
                end
                BRK: begin
                    // E0 after F0 is accepted, so prefix order does not matter
                    if (byte_in == BYTE_EXT)      state_next = EXT_BRK;
                    else if (byte_in != BYTE_BRK) begin
                        done       = 1'b1;
                        done_rel   = 1'b1;
                        state_next = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (byte_in != BYTE_EXT && byte_in != BYTE_BRK) begin
                        done       = 1'b1;
                        done_ext   = 1'b1;
                        done_rel   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Only non-extended codes map onto the held-key bits
    always_comb begin
        trk_hit = 1'b0;
        trk_idx = 2'd0;
        if (!done_ext) begin
            unique case (byte_in)
                8'h1C:   begin trk_hit = 1'b1; trk_idx = 2'd0; end
                8'h32:   begin trk_hit = 1'b1; trk_idx = 2'd1; end
                8'h21:   begin trk_hit = 1'b1; trk_idx = 2'd2; end
                8'h23:   begin trk_hit = 1'b1; trk_idx = 2'd3; end
                default: begin trk_hit = 1'b0; trk_idx = 2'd0; end
            endcase
        end
    end

    always_comb begin
        full     = (count == CNT_W'(FIFO_DEPTH));
        pop      = evt_valid && evt_ready;
        // A repeat press of an already-held key is swallowed when filtering
        push_req = done && !((REPEAT_FILTER != 0) && trk_hit && !done_rel && key_down[trk_idx]);
        // Simultaneous pop frees the slot a full FIFO needs
        push_ok  = push_req && (!full || pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            key_down <= 4'b0000;
            overflow <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            // key_down follows every completed tracked event, even one the FIFO drops
            if (done && trk_hit) key_down[trk_idx] <= !done_rel;
            if (push_req && !push_ok) overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {done_ext, done_rel, byte_in};
    end

    // Show-ahead head, forced to zero while empty so stale entries never leak out
    always_comb begin
        evt_valid   = (count != '0);
        evt_ext     = evt_valid ? mem[rd_ptr][9] : 1'b0;
        evt_release = evt_valid ? mem[rd_ptr][8] : 1'b0;
        evt_code    = evt_valid ? mem[rd_ptr][7:0] : 8'h00;
    end

endmodule

// File: tb/tb_ps2_event_sequencer.sv
// Testbench for ps2_event_sequencer: directed scenarios followed by random
// byte streams, all compared every cycle against a queue-based model.
module tb_ps2_event_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] key_down;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: prefix flags, held keys, event queue {ext,rel,code}
    logic       m_ext;
    logic       m_brk;
    logic [3:0] m_keys;
    logic       m_ovf;
    logic [9:0] q[$];

    ps2_event_sequencer #(.FIFO_DEPTH(DEPTH), .REPEAT_FILTER(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .evt_code    (evt_code),
        .evt_ext     (evt_ext),
        .evt_release (evt_release),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .key_down    (key_down),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int key_index(input logic [7:0] code);
        logic [7:0] codes [4] = '{8'h1C, 8'h32, 8'h21, 8'h23};
        for (int i = 0; i < 4; i++) if (codes[i] == code) return i;
        return -1;
    endfunction

    // Advance the model by one clock given this cycle's inputs
    task automatic model_cycle(input logic bv, input logic [7:0] b, input logic rdy);
        logic       fire = 1'b0;
        logic       e_ext = 1'b0;
        logic       e_rel = 1'b0;
        logic       want;
        logic       do_pop;
        int         k;
        do_pop = (q.size() != 0) && rdy;
        if (bv) begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (!m_ext && !m_brk &&
                     (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
                // discarded
            end else begin
                fire  = 1'b1;
                e_ext = m_ext;
                e_rel = m_brk;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        if (do_pop) void'(q.pop_front());
        if (fire) begin
            k    = e_ext ? -1 : key_index(b);
            want = 1'b1;
            if (k >= 0) begin
                if (!e_rel && m_keys[k]) want = 1'b0;
                m_keys[k] = !e_rel;
            end
            if (want) begin
                if (q.size() < DEPTH) q.push_back({e_ext, e_rel, b});
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("evt_valid", evt_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("evt_code", evt_code, q[0][7:0]);
            check("evt_ext", evt_ext, q[0][9]);
            check("evt_release", evt_release, q[0][8]);
        end
        check("key_down", key_down, m_keys);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic rdy);
        byte_valid = bv;
        byte_in    = b;
        evt_ready  = rdy;
        model_cycle(bv, b, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        evt_ready  = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_keys = 4'b0000;
        m_ovf  = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", evt_valid, 1'b0);
        check("rst_code", evt_code, 8'h00);
        check("rst_ext", evt_ext, 1'b0);
        check("rst_rel", evt_release, 1'b0);
        check("rst_keys", key_down, 4'b0000);
        check("rst_ovf", overflow, 1'b0);
    endtask

    // Pop the head with ready=1 and confirm it matches the expected code
    task automatic drain_expect(input string tag, input logic [9:0] exp);
        check(tag, {evt_ext, evt_release, evt_code}, exp);
        step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h1C,
                                  8'h15, 8'h75, 8'h00, 8'hAA, 8'hFA, 8'hFF, 8'h2D};
        reset = 1'b1;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        evt_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Press then release A
        step(1'b1, 8'h1C, 1'b0);
        check("press_a_evt", {evt_ext, evt_release, evt_code}, 10'h01C);
        check("press_a_keys", key_down, 4'b0001);
        step(1'b1, 8'hF0, 1'b1);
        step(1'b1, 8'h1C, 1'b0);
        check("rel_a_evt", {evt_ext, evt_release, evt_code}, 10'h11C);
        check("rel_a_keys", key_down, 4'b0000);

        // Typematic repeat suppression
        do_reset();
        step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h1C, 1'b0);
        drain_expect("typ_first", 10'h01C);
        drain_expect("typ_second", 10'h11C);
        check("typ_empty", evt_valid, 1'b0);
        check("typ_ovf", overflow, 1'b0);

        // Extended break, both prefix orders
        do_reset();
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h75, 1'b0);
        drain_expect("ext_ef", 10'h375);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'h75, 1'b0);
        drain_expect("ext_fe", 10'h375);
        check("ext_keys", key_down, 4'b0000);

        // Backpressure and overflow
        do_reset();
        foreach (pool[i]) if (i < 0) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h15, 1'b0);
        step(1'b1, 8'h1D, 1'b0);
        step(1'b1, 8'h24, 1'b0);
        step(1'b1, 8'h2D, 1'b0);
        step(1'b1, 8'h2C, 1'b0);
        check("bp_ovf", overflow, 1'b1);
        drain_expect("bp_d0", 10'h015);
        drain_expect("bp_d1", 10'h01D);
        drain_expect("bp_d2", 10'h024);
        drain_expect("bp_d3", 10'h02D);
        check("bp_empty", evt_valid, 1'b0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        step(1'b1, 8'h15, 1'b0);
        step(1'b1, 8'h1D, 1'b0);
        step(1'b1, 8'h24, 1'b0);
        step(1'b1, 8'h2D, 1'b0);
        step(1'b1, 8'h2C, 1'b1);
        check("full_pp_ovf", overflow, 1'b0);
        drain_expect("full_pp_d0", 10'h01D);
        drain_expect("full_pp_d1", 10'h024);
        drain_expect("full_pp_d2", 10'h02D);
        drain_expect("full_pp_d3", 10'h02C);
        check("full_pp_empty", evt_valid, 1'b0);

        // Reset in the middle of a break prefix
        do_reset();
        step(1'b1, 8'hF0, 1'b0);
        do_reset();
        step(1'b1, 8'h1C, 1'b0);
        check("midrst_evt", {evt_ext, evt_release, evt_code}, 10'h01C);
        check("midrst_keys", key_down, 4'b0001);

        // Random streams, back-to-back bytes and random consumer readiness
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int n = 0; n < 1500; n++) begin
                logic       bv;
                logic [7:0] b;
                bv = ($urandom_range(0, 3) != 0);
                b  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
                step(bv, b, ($urandom_range(0, 2 + r) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
